// File: rtl/debounced_updown_counter.sv
// Purpose : synchronise and debounce three raw push-buttons (up, down, clear) and drive a
//           CNT_WIDTH-bit up/down counter shown on the LEDs, with wrap-or-saturate and
//           optional hold-to-auto-repeat on up/down.
// Ports   : sysclk (clock), reset_btn (sync active-high reset), btn_up/btn_down/btn_clr
//           (raw async buttons), led (registered count), count_evt (1-cycle pulse when led
//           changes), at_max / at_min (led at all-ones / zero, decoded from the led register).
module debounced_updown_counter #(
   parameter int CNT_WIDTH       = 4,
   parameter int DEBOUNCE_CYCLES = 1_250_000,
   parameter int WRAP            = 1,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 25_000_000
) (
   input  logic                 sysclk,
   input  logic                 reset_btn,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_clr,
   output logic [CNT_WIDTH-1:0] led,
   output logic                 count_evt,
   output logic                 at_max,
   output logic                 at_min
);

   // Stability counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // One timer per repeat FSM serves both the initial delay and the repeat period,
   // so it is sized for the larger of the two.
   localparam int TMR_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W    = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;
   localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
   localparam logic [TMR_W-1:0] PER_LAST = TMR_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MIN = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RPT  = 2'd2
   } rpt_state_e;

   // Bit order for all per-button vectors: [0]=up, [1]=down, [2]=clr.
   logic [2:0]      btn_raw;
   logic [2:0]      sync1_q;
   logic [2:0]      sync2_q;
   logic [2:0]      level_q;
   logic [2:0]      level_dly_q;
   logic [DB_W-1:0] db_cnt_q [3];
   logic [2:0]      press;
   logic [1:0]      step;

   logic [CNT_WIDTH-1:0] led_q;
   logic [CNT_WIDTH-1:0] led_d;
   logic                 count_evt_q;

   assign btn_raw = {btn_clr, btn_down, btn_up};

   // ------------------------------------------------------------------
   // Synchroniser + debounce: the level only follows the synchronised
   // input after DEBOUNCE_CYCLES consecutive disagreeing samples; any
   // agreeing sample restarts the count, so short glitches vanish.
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk) begin
      if (reset_btn) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               level_q[i]  <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Rising edge of the debounced level; releases are deliberately ignored.
   assign press = level_q & ~level_dly_q;

   // ------------------------------------------------------------------
   // Step generation for up (g=0) and down (g=1). With REPEAT_DELAY==0
   // the FSM never leaves IDLE and a step is just the press pulse.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < 2; g++) begin : g_rpt
      rpt_state_e       state_q;
      rpt_state_e       state_d;
      logic [TMR_W-1:0] tmr_q;
      logic [TMR_W-1:0] tmr_d;
      logic             rpt_step;

      always_ff @(posedge sysclk) begin
         if (reset_btn) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         tmr_d    = tmr_q;
         rpt_step = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (press[g]) begin
                  rpt_step = 1'b1;
                  tmr_d    = '0;
                  if (REPEAT_DELAY != 0) begin
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!level_q[g]) begin
                  state_d = ST_IDLE;
               end else if (tmr_q == DLY_LAST) begin
                  rpt_step = 1'b1;
                  tmr_d    = '0;
                  state_d  = ST_RPT;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
            ST_RPT: begin
               if (!level_q[g]) begin
                  state_d = ST_IDLE;
               end else if (tmr_q == PER_LAST) begin
                  rpt_step = 1'b1;
                  tmr_d    = '0;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end
         endcase
      end

      assign step[g] = rpt_step;
   end

   // ------------------------------------------------------------------
   // Counter: clear wins, simultaneous up+down cancel, then up, then down.
   // ------------------------------------------------------------------
   always_comb begin
      led_d = led_q;
      if (press[2]) begin
         led_d = CNT_MIN;
      end else if (step[0] && step[1]) begin
         led_d = led_q;
      end else if (step[0]) begin
         if (led_q == CNT_MAX) begin
            led_d = (WRAP != 0) ? CNT_MIN : CNT_MAX;
         end else begin
            led_d = led_q + CNT_WIDTH'(1);
         end
      end else if (step[1]) begin
         if (led_q == CNT_MIN) begin
            led_d = (WRAP != 0) ? CNT_MAX : CNT_MIN;
         end else begin
            led_d = led_q - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset_btn) begin
         led_q       <= '0;
         count_evt_q <= 1'b0;
      end else begin
         led_q       <= led_d;
         // Saturated steps and clear-at-zero leave led alone, so no event.
         count_evt_q <= (led_d != led_q);
      end
   end

   assign led       = led_q;
   assign count_evt = count_evt_q;
   assign at_max    = (led_q == CNT_MAX);
   assign at_min    = (led_q == CNT_MIN);

endmodule
